// File: rtl/bus_master_initiator.sv
// bus_master_initiator
//   Requesting end of a 68000-style AS/UDS/LDS/WR/DTACK bus cycle. An on-FPGA
//   agent (loader or debug engine) hands over one word request. The block runs
//   exactly one bus cycle for it and then reports completion or bus error.
//   All bus strobes are active-high.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in WAIT or RELEASE before abort (1..65535)
//
// Ports
//   MCLK_IN       in     bus clock, all state changes on the rising edge
//   RESET_IN      in     asynchronous active-high reset
//   REQ_IN        in     request, looked at only while idle
//   REQ_WR_IN     in     1 = write, 0 = read
//   REQ_UDS_IN    in     upper (even) byte lane enable
//   REQ_LDS_IN    in     lower (odd) byte lane enable
//   REQ_ADDR_IN   in     24-bit byte address
//   REQ_WDATA_IN  in     16-bit write data
//   DTACK_IN      in     data acknowledge from the responder
//   DATA          inout  bus data, driven only during a write cycle
//   ADDR          out    registered bus address
//   AS, UDS, LDS  out    address and data strobes
//   WR            out    write direction
//   BUSY          out    high from accept through the DONE cycle
//   DONE          out    one-cycle completion pulse
//   RDATA         out    read data captured at DTACK
//   BUSERR        out    valid with DONE, 1 = aborted or illegal request
module bus_master_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        MCLK_IN,
    input  logic        RESET_IN,
    input  logic        REQ_IN,
    input  logic        REQ_WR_IN,
    input  logic        REQ_UDS_IN,
    input  logic        REQ_LDS_IN,
    input  logic [23:0] REQ_ADDR_IN,
    input  logic [15:0] REQ_WDATA_IN,
    input  logic        DTACK_IN,
    inout  wire  [15:0] DATA,
    output logic [23:0] ADDR,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        WR,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RDATA,
    output logic        BUSERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              laneU_q, laneU_d;
    logic              laneL_q, laneL_d;
    logic              as_q, as_d;
    logic              uds_q, uds_d;
    logic              lds_q, lds_d;
    logic              dataEn_q, dataEn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              buserr_q, buserr_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cntInc;

    // Saturating increment so the counter can never wrap back to zero.
    assign cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state and output logic. The strobes, direction and data enable are
    // all registered, so the bus only ever sees clean edge-aligned changes.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wr_d     = wr_q;
        laneU_d  = laneU_q;
        laneL_d  = laneL_q;
        as_d     = as_q;
        uds_d    = uds_q;
        lds_d    = lds_q;
        dataEn_d = dataEn_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        buserr_d = buserr_q;
        abort_d  = abort_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // BUSY is still high here during the DONE cycle; it drops
                // unless a new request is accepted on the same edge.
                busy_d = 1'b0;
                if (REQ_IN) begin
                    if (REQ_UDS_IN || REQ_LDS_IN) begin
                        addr_d   = REQ_ADDR_IN;
                        wdata_d  = REQ_WDATA_IN;
                        wr_d     = REQ_WR_IN;
                        laneU_d  = REQ_UDS_IN;
                        laneL_d  = REQ_LDS_IN;
                        dataEn_d = REQ_WR_IN;
                        abort_d  = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = S_ADDR;
                    end else begin
                        // A request with no byte lane is refused without
                        // touching the bus.
                        done_d   = 1'b1;
                        buserr_d = 1'b1;
                    end
                end
            end

            S_ADDR: begin
                as_d    = 1'b1;
                uds_d   = laneU_q;
                lds_d   = laneL_q;
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (DTACK_IN) begin
                    if (!wr_q) begin
                        rdata_d = DATA;
                    end
                    as_d    = 1'b0;
                    uds_d   = 1'b0;
                    lds_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    as_d    = 1'b0;
                    uds_d   = 1'b0;
                    lds_d   = 1'b0;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cntInc;
                end
            end

            S_RELEASE: begin
                // Finish once the responder lets go of DTACK, or give up if
                // it stays stuck high for the whole timeout window.
                if (!DTACK_IN || (cnt_q == CNT_LAST)) begin
                    done_d   = 1'b1;
                    buserr_d = abort_q | DTACK_IN;
                    abort_d  = abort_q | DTACK_IN;
                    wr_d     = 1'b0;
                    dataEn_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cntInc;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register. Reset is asynchronous so strobes drop immediately
    // even in the middle of a bus cycle.
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wr_q     <= 1'b0;
            laneU_q  <= 1'b0;
            laneL_q  <= 1'b0;
            as_q     <= 1'b0;
            uds_q    <= 1'b0;
            lds_q    <= 1'b0;
            dataEn_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            buserr_q <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wr_q     <= wr_d;
            laneU_q  <= laneU_d;
            laneL_q  <= laneL_d;
            as_q     <= as_d;
            uds_q    <= uds_d;
            lds_q    <= lds_d;
            dataEn_q <= dataEn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            buserr_q <= buserr_d;
            abort_q  <= abort_d;
            cnt_q    <= cnt_d;
        end
    end

    // The data driver enable is a register that is only set for writes, so
    // the initiator never fights the responder during a read.
    assign DATA   = dataEn_q ? wdata_q : 16'hzzzz;
    assign ADDR   = addr_q;
    assign AS     = as_q;
    assign UDS    = uds_q;
    assign LDS    = lds_q;
    assign WR     = wr_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RDATA  = rdata_q;
    assign BUSERR = buserr_q;

endmodule

// File: tb/tb_bus_master_initiator.sv
// tb_bus_master_initiator
//   Self-checking bench for bus_master_initiator. A scheduled responder drives
//   DTACK/DATA; expected completion timing, error status and read data come
//   from a timing model of the bus cycle (ADDR cycle, WAIT samples, RELEASE
//   samples) kept here in the bench. DATA has pull-ups so an undriven bus
//   reads as 16'hFFFF.
module tb_bus_master_initiator;

    localparam int T = 8;

    logic        MCLK_IN = 1'b0;
    logic        RESET_IN;
    logic        REQ_IN, REQ_WR_IN, REQ_UDS_IN, REQ_LDS_IN, DTACK_IN;
    logic [23:0] REQ_ADDR_IN;
    logic [15:0] REQ_WDATA_IN;
    wire  [15:0] DATA;
    logic [23:0] ADDR;
    logic        AS, UDS, LDS, WR, BUSY, DONE, BUSERR;
    logic [15:0] RDATA;

    logic        respDrive;
    logic [15:0] respData;

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] modelRdata;

    int          obsDoneEdge, obsDoneCount, obsAsCycles;
    logic        obsUds, obsLds, obsBuserr, obsBusyAtDone, obsBusyAfter, obsDataBad;
    logic [15:0] obsRdata;
    logic [23:0] obsAddr;

    bus_master_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .MCLK_IN(MCLK_IN), .RESET_IN(RESET_IN), .REQ_IN(REQ_IN), .REQ_WR_IN(REQ_WR_IN),
        .REQ_UDS_IN(REQ_UDS_IN), .REQ_LDS_IN(REQ_LDS_IN), .REQ_ADDR_IN(REQ_ADDR_IN),
        .REQ_WDATA_IN(REQ_WDATA_IN), .DTACK_IN(DTACK_IN), .DATA(DATA), .ADDR(ADDR),
        .AS(AS), .UDS(UDS), .LDS(LDS), .WR(WR), .BUSY(BUSY), .DONE(DONE),
        .RDATA(RDATA), .BUSERR(BUSERR)
    );

    assign DATA = respDrive ? respData : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : gPull
        pullup (DATA[i]);
    end

    always #5 MCLK_IN = ~MCLK_IN;

    // Model: edge index (accept edge = 0) after which DONE is visible.
    // w = WAIT samples without DTACK before it arrives (w >= T: never arrives),
    // h = RELEASE samples with DTACK still high.
    function automatic int modelDoneEdge(input int w, input int h);
        if (w >= T)      return 2 + T;
        else if (h >= T) return 2 + w + T;
        else             return 3 + w + h;
    endfunction

    function automatic logic modelErr(input int w, input int h);
        return (w >= T) || (h >= T);
    endfunction

    function automatic int modelAsCycles(input int w);
        return (w >= T) ? T : w + 1;
    endfunction

    // Runs one transfer from a negedge, scheduling the responder by edge index,
    // and records what was seen on the bus.
    task automatic applyStimulus(input logic wr, input logic [1:0] lanes, input logic [23:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] rdat,
                                 input int w, input int h);
        logic [15:0] expData;
        int kk;
        obsDoneEdge = -1; obsDoneCount = 0; obsAsCycles = 0;
        obsUds = 0; obsLds = 0; obsBuserr = 0; obsBusyAtDone = 0; obsBusyAfter = 1;
        obsDataBad = 0; obsRdata = '0; obsAddr = '0;
        REQ_IN = 1; REQ_WR_IN = wr; REQ_UDS_IN = lanes[1]; REQ_LDS_IN = lanes[0];
        REQ_ADDR_IN = addr; REQ_WDATA_IN = wdata; respData = rdat;
        @(posedge MCLK_IN);
        @(negedge MCLK_IN);
        REQ_IN = 0;
        for (int k = 0; k <= 40; k++) begin
            if (AS) obsAsCycles++;
            if (UDS) obsUds = 1;
            if (LDS) obsLds = 1;
            if (DONE) begin
                obsDoneCount++;
                if (obsDoneEdge < 0) begin
                    obsDoneEdge = k; obsBuserr = BUSERR; obsRdata = RDATA;
                    obsBusyAtDone = BUSY; obsAddr = ADDR;
                end
            end
            if (respDrive) expData = respData;
            else if (wr && obsDoneEdge < 0) expData = wdata;
            else expData = 16'hFFFF;
            if (DATA !== expData) obsDataBad = 1;
            if (obsDoneEdge >= 0 && k == obsDoneEdge + 1) begin
                obsBusyAfter = BUSY;
                break;
            end
            kk = k + 1;
            DTACK_IN  = (w < T) && (kk >= 2 + w) && (kk < 3 + w + h);
            respDrive = DTACK_IN && !wr;
            @(posedge MCLK_IN);
            @(negedge MCLK_IN);
        end
        DTACK_IN = 0; respDrive = 0;
    endtask

    task automatic test_reset;
        RESET_IN = 1;
        @(negedge MCLK_IN);
        checkCount++; if ({AS, UDS, LDS, WR, BUSY, DONE, BUSERR} !== 7'b0)
            $display("[TB] FAIL reset_ctrl: got %b want 0000000", {AS, UDS, LDS, WR, BUSY, DONE, BUSERR}); else passCount++;
        checkCount++; if (RDATA !== 16'h0 || ADDR !== 24'h0)
            $display("[TB] FAIL reset_regs: got rdata=%h addr=%h want 0/0", RDATA, ADDR); else passCount++;
        checkCount++; if (DATA !== 16'hFFFF)
            $display("[TB] FAIL reset_data_z: got %h want FFFF(undriven)", DATA); else passCount++;
        RESET_IN = 0;
        modelRdata = 16'h0;
        @(negedge MCLK_IN);
    endtask

    task automatic test_write_single;
        applyStimulus(1'b1, 2'b01, 24'h100001, 16'h00A0, 16'h0, 0, 0);
        checkCount++; if (obsDoneEdge !== 3)
            $display("[TB] FAIL wr1_done_edge: got %0d want 3", obsDoneEdge); else passCount++;
        checkCount++; if (obsAsCycles !== 1 || obsUds !== 1'b0 || obsLds !== 1'b1)
            $display("[TB] FAIL wr1_strobes: got as=%0d u=%b l=%b want 1 0 1", obsAsCycles, obsUds, obsLds); else passCount++;
        checkCount++; if (obsDataBad !== 1'b0)
            $display("[TB] FAIL wr1_data_bus: got bad=%b want 0", obsDataBad); else passCount++;
        checkCount++; if (obsBuserr !== 1'b0 || obsBusyAtDone !== 1'b1 || obsBusyAfter !== 1'b0 || obsDoneCount !== 1)
            $display("[TB] FAIL wr1_status: got err=%b busy=%b/%b dones=%0d want 0 1/0 1",
                     obsBuserr, obsBusyAtDone, obsBusyAfter, obsDoneCount); else passCount++;
        checkCount++; if (obsAddr !== 24'h100001 || obsRdata !== modelRdata)
            $display("[TB] FAIL wr1_addr_rdata: got %h/%h want 100001/%h", obsAddr, obsRdata, modelRdata); else passCount++;
    endtask

    task automatic test_read_wait;
        applyStimulus(1'b0, 2'b11, 24'h000000, 16'h1234, 16'h4E71, 3, 0);
        modelRdata = 16'h4E71;
        checkCount++; if (obsDoneEdge !== 6)
            $display("[TB] FAIL rd_done_edge: got %0d want 6", obsDoneEdge); else passCount++;
        checkCount++; if (obsRdata !== modelRdata)
            $display("[TB] FAIL rd_rdata: got %h want %h", obsRdata, modelRdata); else passCount++;
        checkCount++; if (obsDataBad !== 1'b0 || obsBuserr !== 1'b0 || obsAsCycles !== 4)
            $display("[TB] FAIL rd_bus: got bad=%b err=%b as=%0d want 0 0 4", obsDataBad, obsBuserr, obsAsCycles); else passCount++;
    endtask

    task automatic test_timeout;
        applyStimulus(1'b0, 2'b11, 24'h00F000, 16'h5555, 16'hBEEF, T, 0);
        checkCount++; if (obsDoneEdge !== 2 + T || obsAsCycles !== T)
            $display("[TB] FAIL tmo_timing: got done=%0d as=%0d want %0d %0d", obsDoneEdge, obsAsCycles, 2 + T, T); else passCount++;
        checkCount++; if (obsBuserr !== 1'b1 || obsRdata !== modelRdata)
            $display("[TB] FAIL tmo_status: got err=%b rdata=%h want 1 %h", obsBuserr, obsRdata, modelRdata); else passCount++;
    endtask

    task automatic test_release_hold;
        int hs[3] = '{5, T - 1, T + 2};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b10, 24'h000200 + 24'(i), 16'h1357, 16'h0, 0, hs[i]);
            checkCount++; if (obsDoneEdge !== modelDoneEdge(0, hs[i]) || obsBuserr !== modelErr(0, hs[i]))
                $display("[TB] FAIL hold_h%0d: got done=%0d err=%b want %0d %b", hs[i], obsDoneEdge, obsBuserr,
                         modelDoneEdge(0, hs[i]), modelErr(0, hs[i])); else passCount++;
        end
    endtask

    task automatic test_illegal_and_back_to_back;
        int n;
        REQ_IN = 1; REQ_WR_IN = 1; REQ_UDS_IN = 0; REQ_LDS_IN = 0; REQ_ADDR_IN = 24'h123456;
        @(posedge MCLK_IN);
        @(negedge MCLK_IN);
        REQ_IN = 0;
        checkCount++; if (DONE !== 1'b1 || BUSERR !== 1'b1 || AS !== 1'b0)
            $display("[TB] FAIL illegal_done: got done=%b err=%b as=%b want 1 1 0", DONE, BUSERR, AS); else passCount++;
        @(negedge MCLK_IN);
        checkCount++; if (DONE !== 1'b0 || AS !== 1'b0 || BUSERR !== 1'b1)
            $display("[TB] FAIL illegal_after: got done=%b as=%b err=%b want 0 0 1", DONE, AS, BUSERR); else passCount++;
        // Two writes with REQ_IN held; responder simply follows AS.
        REQ_IN = 1; REQ_WR_IN = 1; REQ_UDS_IN = 1; REQ_LDS_IN = 1;
        REQ_ADDR_IN = 24'hA00000; REQ_WDATA_IN = 16'h1111;
        n = 0;
        do begin
            @(posedge MCLK_IN); @(negedge MCLK_IN);
            DTACK_IN = AS; n++;
        end while (!DONE && n < 30);
        checkCount++; if (DONE !== 1'b1 || BUSERR !== 1'b0)
            $display("[TB] FAIL b2b_first: got done=%b err=%b want 1 0", DONE, BUSERR); else passCount++;
        REQ_ADDR_IN = 24'hB00002; REQ_WDATA_IN = 16'h2222;
        @(posedge MCLK_IN); @(negedge MCLK_IN);
        REQ_IN = 0;
        checkCount++; if (ADDR !== 24'hB00002 || BUSY !== 1'b1 || WR !== 1'b1 || AS !== 1'b0 || DONE !== 1'b0 || DATA !== 16'h2222)
            $display("[TB] FAIL b2b_addr_cycle: got addr=%h busy=%b wr=%b as=%b done=%b data=%h want B00002 1 1 0 0 2222",
                     ADDR, BUSY, WR, AS, DONE, DATA); else passCount++;
        n = 0;
        do begin
            DTACK_IN = AS;
            @(posedge MCLK_IN); @(negedge MCLK_IN);
            n++;
        end while (!DONE && n < 30);
        DTACK_IN = 0;
        checkCount++; if (n !== 3 || BUSERR !== 1'b0)
            $display("[TB] FAIL b2b_second: got edges=%0d err=%b want 3 0", n, BUSERR); else passCount++;
        @(negedge MCLK_IN);
    endtask

    task automatic test_reset_mid_cycle;
        int dones;
        REQ_IN = 1; REQ_WR_IN = 1; REQ_UDS_IN = 1; REQ_LDS_IN = 1;
        REQ_ADDR_IN = 24'hC0FFEE; REQ_WDATA_IN = 16'h7E57;
        @(posedge MCLK_IN); @(negedge MCLK_IN);
        REQ_IN = 0;
        @(posedge MCLK_IN); @(posedge MCLK_IN);
        #2;
        RESET_IN = 1;
        #1;
        checkCount++; if ({AS, UDS, LDS, WR, BUSY} !== 5'b0 || DATA !== 16'hFFFF)
            $display("[TB] FAIL midreset_drop: got ctrl=%b data=%h want 00000 FFFF", {AS, UDS, LDS, WR, BUSY}, DATA); else passCount++;
        modelRdata = 16'h0;
        @(negedge MCLK_IN);
        RESET_IN = 0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge MCLK_IN);
            if (DONE) dones++;
        end
        checkCount++; if (dones !== 0)
            $display("[TB] FAIL midreset_no_done: got %0d want 0", dones); else passCount++;
        applyStimulus(1'b0, 2'b01, 24'h000010, 16'h0, 16'h600D, 1, 1);
        modelRdata = 16'h600D;
        checkCount++; if (obsDoneEdge !== modelDoneEdge(1, 1) || obsRdata !== modelRdata || obsBuserr !== 1'b0)
            $display("[TB] FAIL midreset_next: got done=%0d rdata=%h err=%b want %0d %h 0",
                     obsDoneEdge, obsRdata, obsBuserr, modelDoneEdge(1, 1), modelRdata); else passCount++;
    endtask

    task automatic test_random;
        logic        wr;
        logic [1:0]  lanes;
        logic [15:0] wd, rd;
        int          w, h, expDone;
        logic        expErr;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            lanes = 2'($urandom_range(1, 3));
            wd = 16'($urandom_range(0, 16'hFFFE));
            rd = 16'($urandom_range(0, 16'hFFFE));
            w = $urandom_range(0, T);
            h = $urandom_range(0, T - 1);
            applyStimulus(wr, lanes, 24'($urandom), wd, rd, w, h);
            expDone = modelDoneEdge(w, h);
            expErr = modelErr(w, h);
            if (!wr && w < T) modelRdata = rd;
            checkCount++; if (obsDoneEdge !== expDone || obsBuserr !== expErr)
                $display("[TB] FAIL rnd%0d_done: got edge=%0d err=%b want %0d %b", i, obsDoneEdge, obsBuserr, expDone, expErr); else passCount++;
            checkCount++; if (obsAsCycles !== modelAsCycles(w) || {obsUds, obsLds} !== lanes)
                $display("[TB] FAIL rnd%0d_strobes: got as=%0d lanes=%b want %0d %b", i, obsAsCycles, {obsUds, obsLds},
                         modelAsCycles(w), lanes); else passCount++;
            checkCount++; if (obsRdata !== modelRdata || obsDataBad !== 1'b0)
                $display("[TB] FAIL rnd%0d_data: got rdata=%h bad=%b want %h 0", i, obsRdata, obsDataBad, modelRdata); else passCount++;
            checkCount++; if (obsBusyAtDone !== 1'b1 || obsBusyAfter !== 1'b0 || obsDoneCount !== 1)
                $display("[TB] FAIL rnd%0d_busy: got %b/%b dones=%0d want 1/0 1", i, obsBusyAtDone, obsBusyAfter, obsDoneCount); else passCount++;
        end
    endtask

    initial begin
        RESET_IN = 1; REQ_IN = 0; REQ_WR_IN = 0; REQ_UDS_IN = 0; REQ_LDS_IN = 0;
        REQ_ADDR_IN = '0; REQ_WDATA_IN = '0; DTACK_IN = 0; respDrive = 0; respData = '0;
        modelRdata = '0;
        test_reset;
        test_write_single;
        test_read_wait;
        test_timeout;
        test_release_hold;
        test_illegal_and_back_to_back;
        test_reset_mid_cycle;
        test_random;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
